// File: rtl/ifmap_spad_writer.sv
// Producer-side writer for the PE ifmap scratchpad: streams one row per start
// into a circular buffer and tracks occupancy against consumer releases.
module ifmap_spad_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int SPAD_SIZE  = 16,
  parameter int ADDR_WIDTH = $clog2(SPAD_SIZE),
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_clear,
  input  logic [LEN_WIDTH-1:0]  i_row_len,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  input  logic                  i_rel_en,
  input  logic [ADDR_WIDTH:0]   i_rel_num,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [ADDR_WIDTH-1:0] o_rd_base,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_row_done,
  output logic                  o_busy,
  output logic                  o_rel_err
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SPAD_SIZE - 1);
  localparam logic [LW-1:0]         LVL_FULL  = LW'(SPAD_SIZE);
  localparam logic [LW:0]           SIZE_X    = (LW + 1)'(SPAD_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_base;
  logic [LW-1:0]         r_level;
  logic [LEN_WIDTH-1:0]  r_loaded;
  logic [LEN_WIDTH-1:0]  r_row_len;
  logic                  r_row_done;
  logic                  r_rel_err;

  logic                  w_busy;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_last;
  logic [LEN_WIDTH:0]    w_loaded_inc;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
  logic [LW-1:0]         w_rel_amt;
  logic [LW:0]           w_level_acc;
  logic                  w_over;
  logic [LW-1:0]         w_level_next;
  logic [LW:0]           w_rd_sum;
  logic [ADDR_WIDTH-1:0] w_rd_base_next;

  assign w_busy     = (r_state == LOAD);
  assign w_full     = (r_level == LVL_FULL);
  assign o_in_ready = w_busy && !w_full && (r_loaded < r_row_len);
  assign w_accept   = i_in_valid && o_in_ready;

  assign w_loaded_inc = {1'b0, r_loaded} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign w_last       = w_accept && (w_loaded_inc == {1'b0, r_row_len});

  assign w_wr_ptr_next = !w_accept             ? r_wr_ptr :
                         (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;

  // Release is bounded by level+accept (<= SPAD_SIZE) unless it overflows,
  // so a single conditional subtract is enough to wrap rd_base.
  assign w_rel_amt   = i_rel_en ? i_rel_num : '0;
  assign w_level_acc = {1'b0, r_level} + {{LW{1'b0}}, w_accept};
  assign w_over      = ({1'b0, w_rel_amt} > w_level_acc);
  assign w_level_next = w_over ? '0 : LW'(w_level_acc - {1'b0, w_rel_amt});

  assign w_rd_sum = {2'b00, r_rd_base} + {1'b0, w_rel_amt};
  assign w_rd_base_next = w_over             ? w_wr_ptr_next :
                          (w_rd_sum >= SIZE_X) ? ADDR_WIDTH'(w_rd_sum - SIZE_X) :
                                               ADDR_WIDTH'(w_rd_sum);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_base  <= '0;
      r_level    <= '0;
      r_loaded   <= '0;
      r_row_len  <= '0;
      r_row_done <= 1'b0;
      r_rel_err  <= 1'b0;
    end else if (i_clear) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_base  <= '0;
      r_level    <= '0;
      r_loaded   <= '0;
      r_row_len  <= '0;
      r_row_done <= 1'b0;
      r_rel_err  <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_base  <= w_rd_base_next;
      r_level    <= w_level_next;
      r_row_done <= w_last;
      if (w_over) r_rel_err <= 1'b1;
      case (r_state)
        IDLE, DONE: begin
          if (i_start && (i_row_len != '0)) begin
            r_state   <= LOAD;
            r_row_len <= i_row_len;
            r_loaded  <= '0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_loaded <= LEN_WIDTH'(w_loaded_inc);
            if (w_last) r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wr_en    = w_accept;
  assign o_wr_addr  = r_wr_ptr;
  assign o_wr_data  = i_in_data;
  assign o_rd_base  = r_rd_base;
  assign o_level    = r_level;
  assign o_full     = w_full;
  assign o_empty    = (r_level == '0);
  assign o_row_done = r_row_done;
  assign o_busy     = w_busy;
  assign o_rel_err  = r_rel_err;

endmodule

// File: tb/tb_ifmap_spad_writer.sv
// Scoreboard bench for ifmap_spad_writer on a 12-entry (non power of 2) spad:
// expected writes are queued by the stimulus and checked by a write monitor.
module tb_ifmap_spad_writer;

  localparam int DW   = 8;
  localparam int SPAD = 12;
  localparam int AW   = 4;
  localparam int LENW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_start = 1'b0;
  logic            i_clear = 1'b0;
  logic [LENW-1:0] i_row_len = '0;
  logic            i_in_valid = 1'b0;
  logic [DW-1:0]   i_in_data = '0;
  logic            i_rel_en = 1'b0;
  logic [AW:0]     i_rel_num = '0;
  logic            o_in_ready, o_wr_en, o_full, o_empty, o_row_done, o_busy, o_rel_err;
  logic [AW-1:0]   o_wr_addr, o_rd_base;
  logic [DW-1:0]   o_wr_data;
  logic [AW:0]     o_level;

  ifmap_spad_writer #(
    .DATA_WIDTH(DW), .SPAD_SIZE(SPAD), .ADDR_WIDTH(AW), .LEN_WIDTH(LENW)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_clear(i_clear),
    .i_row_len(i_row_len), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
    .o_in_ready(o_in_ready), .i_rel_en(i_rel_en), .i_rel_num(i_rel_num),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_rd_base(o_rd_base), .o_level(o_level), .o_full(o_full), .o_empty(o_empty),
    .o_row_done(o_row_done), .o_busy(o_busy), .o_rel_err(o_rel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [AW-1:0] exp_wp = '0;
  logic [DW-1:0] seed = 8'hA0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Queue the element driven this cycle as an expected write at exp_wp.
  task automatic push_exp();
    wr_t e;
    i_in_valid = 1'b1;
    i_in_data  = seed;
    e.addr = exp_wp;
    e.data = seed;
    exp_q.push_back(e);
    seed   = seed + 8'd1;
    exp_wp = (exp_wp == AW'(SPAD - 1)) ? '0 : exp_wp + 1'b1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      push_exp();
      cycle();
    end
    i_in_valid = 1'b0;
  endtask

  task automatic release_n(input int n);
    i_rel_en  = 1'b1;
    i_rel_num = (AW + 1)'(n);
    cycle();
    i_rel_en  = 1'b0;
    i_rel_num = '0;
  endtask

  task automatic start_row(input int len);
    i_start   = 1'b1;
    i_row_len = LENW'(len);
    cycle();
    i_start   = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    cycle();
    i_clear = 1'b0;
    exp_wp  = '0;
  endtask

  // Write monitor: one line per write transaction.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (o_wr_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got addr %0d data %0h, expected no write", o_wr_addr, o_wr_data);
        end else begin
          e = exp_q.pop_front();
          if (o_wr_addr !== e.addr || o_wr_data !== e.data) begin
            n_fail++;
            $display("FAIL wr_txn: got addr %0d data %0h, expected addr %0d data %0h",
                     o_wr_addr, o_wr_data, e.addr, e.data);
          end else begin
            $display("write addr=%0d data=%0h level=%0d", o_wr_addr, o_wr_data, o_level);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(o_level), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_in_ready", 32'(o_in_ready), 0);
    chk("rst_wr_addr", 32'(o_wr_addr), 0);
    rst = 1'b0;
    cycle();

    // Basic row of 5
    start_row(5);
    chk("t1_busy", 32'(o_busy), 1);
    chk("t1_in_ready", 32'(o_in_ready), 1);
    i_in_valid = 1'b1;
    stream(5);
    chk("t1_row_done", 32'(o_row_done), 1);
    chk("t1_busy_done", 32'(o_busy), 0);
    chk("t1_in_ready_done", 32'(o_in_ready), 0);
    chk("t1_level", 32'(o_level), 5);
    cycle();
    chk("t1_row_done_pulse", 32'(o_row_done), 0);

    do_clear();
    chk("clr_level", 32'(o_level), 0);
    chk("clr_wr_addr", 32'(o_wr_addr), 0);
    chk("clr_busy", 32'(o_busy), 0);

    // Full backpressure: row longer than the spad
    start_row(20);
    stream(12);
    chk("t2_full", 32'(o_full), 1);
    chk("t2_level", 32'(o_level), 12);
    chk("t2_in_ready", 32'(o_in_ready), 0);
    chk("t2_wr_ptr", 32'(o_wr_addr), 0);
    i_in_valid = 1'b1;
    i_start = 1'b1;
    i_row_len = 8'd3;
    cycle();
    i_start = 1'b0;
    chk("t2_hold_level", 32'(o_level), 12);
    chk("t2_hold_busy", 32'(o_busy), 1);
    release_n(3);
    i_in_valid = 1'b0;
    chk("t2_rel_level", 32'(o_level), 9);
    chk("t2_rel_rd_base", 32'(o_rd_base), 3);
    chk("t2_resume_ready", 32'(o_in_ready), 1);
    stream(3);
    chk("t2_refull", 32'(o_full), 1);
    chk("t2_refull_ready", 32'(o_in_ready), 0);

    // Simultaneous accept and release
    release_n(4);
    chk("t3_level8", 32'(o_level), 8);
    chk("t3_rd_base7", 32'(o_rd_base), 7);
    push_exp();
    i_rel_en  = 1'b1;
    i_rel_num = 5'd2;
    cycle();
    i_in_valid = 1'b0;
    i_rel_en   = 1'b0;
    i_rel_num  = '0;
    chk("t3_level", 32'(o_level), 7);
    chk("t3_rd_base", 32'(o_rd_base), 9);
    chk("t3_wr_ptr", 32'(o_wr_addr), 4);

    // Finish the 20-element row, then wrap rd_base
    stream(4);
    chk("t4_row_done", 32'(o_row_done), 1);
    chk("t4_level", 32'(o_level), 11);
    chk("t4_busy", 32'(o_busy), 0);
    release_n(5);
    chk("t4_rd_wrap", 32'(o_rd_base), 2);
    chk("t4_level_rel", 32'(o_level), 6);

    // Zero release, then over-release
    release_n(3);
    release_n(0);
    chk("t5_zero_rel_level", 32'(o_level), 3);
    chk("t5_zero_rel_base", 32'(o_rd_base), 5);
    release_n(5);
    chk("t5_over_level", 32'(o_level), 0);
    chk("t5_over_rd_base", 32'(o_rd_base), 8);
    chk("t5_rel_err", 32'(o_rel_err), 1);
    cycle();
    cycle();
    chk("t5_rel_err_sticky", 32'(o_rel_err), 1);
    do_clear();
    chk("t5_clr_rel_err", 32'(o_rel_err), 0);
    chk("t5_clr_rd_base", 32'(o_rd_base), 0);
    chk("t5_clr_busy", 32'(o_busy), 0);

    // Async reset mid-LOAD
    start_row(6);
    stream(3);
    chk("t6_level_pre", 32'(o_level), 3);
    i_in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_level", 32'(o_level), 0);
    chk("t6_async_busy", 32'(o_busy), 0);
    chk("t6_async_wr_addr", 32'(o_wr_addr), 0);
    chk("t6_async_wr_en", 32'(o_wr_en), 0);
    i_in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    exp_wp = '0;
    start_row(0);
    chk("t6_zero_len_busy", 32'(o_busy), 0);
    cycle();
    chk("t6_zero_len_done", 32'(o_row_done), 0);
    start_row(2);
    stream(2);
    chk("t6_after_rst_done", 32'(o_row_done), 1);
    chk("t6_after_rst_level", 32'(o_level), 2);

    cycle();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
